// File: rtl/mc_main_control_if.sv
// mc_main_control_if: opcode/funct/mem_ready inputs and datapath control outputs of the main control FSM
interface mc_main_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state_dbg;
  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, state_dbg
  );
  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM driving datapath selects and write enables
module mc_main_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  mc_main_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, ADDI_EX = 4'd9,
    ANDI_EX = 4'd10, ORI_EX = 4'd11, IMM_WB = 4'd12, JUMP = 4'd13, JR = 4'd14
  } state_t;
  state_t state_q, state_d;
  logic       mr;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  assign mr = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  // Next-state selection and Moore decode of the state register (memory states gate on mr)
  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mr;
        pc_write  = mr;
        state_d   = mr ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = (bus.funct == 6'b001000) ? JR : EXEC;
          6'b000100:            state_d = BRANCH;
          6'b000010:            state_d = JUMP;
          6'b001000:            state_d = ADDI_EX;
          6'b001100:            state_d = ANDI_EX;
          6'b001101:            state_d = ORI_EX;
          default:              illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == 6'b100011) ? MEMRD : (bus.opcode == 6'b101011) ? MEMWR : FETCH;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mr ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mr;
        state_d    = mr ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = RWB;
      end
      RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      ADDI_EX, ANDI_EX, ORI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (state_q == ANDI_EX) ? 3'b100 : (state_q == ORI_EX) ? 3'b101 : 3'b000;
        state_d   = IMM_WB;
      end
      IMM_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JUMP, JR: begin
        pc_write   = 1'b1;
        pc_source  = (state_q == JR) ? 2'b11 : 2'b10;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end
  // Everything is forced low while reset is held so no write or request escapes
  assign {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
          bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
          bus.PCSource, bus.instr_done, bus.illegal_op, bus.state_dbg} =
    rst_n ? {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op, state_q}
          : 23'd0;
  // State register with synchronous active-low reset to FETCH
  always_ff @(posedge clk) begin
    state_q <= !rst_n ? FETCH : state_d;
  end
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: directed instruction sequences checked against hand-computed control words
module tb_mc_main_control;
  logic clk = 1'b0;
  logic rst_n;
  int   n_asrt = 0;
  int   n_fail = 0;
  logic [18:0] obs_w;
  logic [18:0] w_zero, w_fetch1, w_fetch0, w_decode, w_dec_ill, w_memadr, w_memrd, w_memwb;
  logic [18:0] w_memwr1, w_memwr0, w_exec, w_rwb, w_branch, w_addi, w_andi, w_ori, w_immwb;
  logic [18:0] w_jump, w_jr;
  mc_main_control_if bus ();
  mc_main_control #(.MEM_WAIT_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign obs_w = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                  bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.instr_done, bus.illegal_op};
  function automatic logic [18:0] mk(input bit pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input logic [1:0] ps, input bit dn, il);
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, ps, dn, il};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asrt++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] s, input logic [18:0] w);
    #1;
    chk({tag, " state"}, 32'(bus.state_dbg), 32'(s));
    chk({tag, " ctl"}, 32'(obs_w), 32'(w));
    @(posedge clk);
    #1;
  endtask
  initial begin
    w_zero    = '0;
    w_fetch1  = mk(1,0,0,1,0,1,0,0,0,0, 2'b01, 3'b000, 2'b00, 0,0);
    w_fetch0  = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 3'b000, 2'b00, 0,0);
    w_decode  = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b000, 2'b00, 0,0);
    w_dec_ill = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b000, 2'b00, 0,1);
    w_memadr  = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b000, 2'b00, 0,0);
    w_memrd   = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
    w_memwb   = mk(0,0,0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    w_memwr1  = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);
    w_memwr0  = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
    w_exec    = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 0,0);
    w_rwb     = mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    w_branch  = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 3'b001, 2'b01, 1,0);
    w_addi    = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b000, 2'b00, 0,0);
    w_andi    = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b100, 2'b00, 0,0);
    w_ori     = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b101, 2'b00, 0,0);
    w_immwb   = mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    w_jump    = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,0);
    w_jr      = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b11, 1,0);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b000000;
    bus.funct = 6'b000000;
    @(posedge clk);
    @(posedge clk);
    #1;
    step("reset", 4'd0, w_zero);
    rst_n = 1'b1;
    bus.opcode = 6'b100011;
    step("lw fetch", 4'd0, w_fetch1);
    step("lw decode", 4'd1, w_decode);
    step("lw memadr", 4'd2, w_memadr);
    step("lw memrd", 4'd3, w_memrd);
    step("lw memwb", 4'd4, w_memwb);
    bus.opcode = 6'b000000;
    bus.funct = 6'b100000;
    step("add fetch", 4'd0, w_fetch1);
    step("add decode", 4'd1, w_decode);
    step("add exec", 4'd6, w_exec);
    step("add rwb", 4'd7, w_rwb);
    bus.opcode = 6'b000100;
    step("beq fetch", 4'd0, w_fetch1);
    step("beq decode", 4'd1, w_decode);
    step("beq branch", 4'd8, w_branch);
    bus.opcode = 6'b101011;
    bus.mem_ready = 1'b0;
    step("sw stall0", 4'd0, w_fetch0);
    step("sw stall1", 4'd0, w_fetch0);
    step("sw stall2", 4'd0, w_fetch0);
    bus.mem_ready = 1'b1;
    step("sw fetch", 4'd0, w_fetch1);
    step("sw decode", 4'd1, w_decode);
    step("sw memadr", 4'd2, w_memadr);
    bus.mem_ready = 1'b0;
    step("sw memwr wait", 4'd5, w_memwr0);
    bus.mem_ready = 1'b1;
    step("sw memwr", 4'd5, w_memwr1);
    bus.opcode = 6'b111111;
    step("ill fetch", 4'd0, w_fetch1);
    step("ill decode", 4'd1, w_dec_ill);
    bus.opcode = 6'b001000;
    step("ill next", 4'd0, w_fetch1);
    step("addi decode", 4'd1, w_decode);
    step("addi ex", 4'd9, w_addi);
    step("addi wb", 4'd12, w_immwb);
    bus.opcode = 6'b001100;
    step("andi fetch", 4'd0, w_fetch1);
    step("andi decode", 4'd1, w_decode);
    step("andi ex", 4'd10, w_andi);
    step("andi wb", 4'd12, w_immwb);
    bus.opcode = 6'b001101;
    step("ori fetch", 4'd0, w_fetch1);
    step("ori decode", 4'd1, w_decode);
    step("ori ex", 4'd11, w_ori);
    step("ori wb", 4'd12, w_immwb);
    bus.opcode = 6'b000010;
    step("j fetch", 4'd0, w_fetch1);
    step("j decode", 4'd1, w_decode);
    step("j jump", 4'd13, w_jump);
    bus.opcode = 6'b000000;
    bus.funct = 6'b001000;
    step("jr fetch", 4'd0, w_fetch1);
    step("jr decode", 4'd1, w_decode);
    step("jr jr", 4'd14, w_jr);
    bus.opcode = 6'b100011;
    step("rlw fetch", 4'd0, w_fetch1);
    step("rlw decode", 4'd1, w_decode);
    bus.mem_ready = 1'b0;
    step("rlw memadr", 4'd2, w_memadr);
    step("rlw memrd", 4'd3, w_memrd);
    step("rlw memrd hold", 4'd3, w_memrd);
    rst_n = 1'b0;
    step("rst in memrd", 4'd0, w_zero);
    step("rst held", 4'd0, w_zero);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    step("post rst fetch", 4'd0, w_fetch1);
    step("post rst decode", 4'd1, w_decode);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
